// File: rtl/ysyx_25050147_mc_ctrl.sv
// Multi-cycle sequencing controller for the NPC core: owns PC and IR, drives the
// imem/dmem request/response handshakes and walks each instruction FETCH..WB.
module ysyx_25050147_mc_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_wen,
    input  logic        dmem_rvalid,
    input  logic [4:0]  op_type,
    input  logic [4:0]  rd,
    input  logic [31:0] branch_target,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic        fault,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_IWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_DWAIT  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [4:0] OP_EBREAK = 5'd0;
    localparam logic [4:0] OP_JUMP   = 5'd1;
    localparam logic [4:0] OP_ELSE   = 5'd2;
    localparam logic [4:0] OP_STORE  = 5'd4;
    localparam logic [4:0] OP_LOAD   = 5'd8;
    localparam logic [4:0] OP_BRANCH = 5'd16;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic [4:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  wait_q, wait_d;
    logic        rf_we_q, rf_we_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic        fault_q, fault_d;

    logic [8:0]  wait_inc;
    logic        timeout_hit;
    logic        waiting;

    assign wait_inc    = {1'b0, wait_q} + 9'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 8'd0) && (wait_inc == {1'b0, TIMEOUT_CYCLES});
    assign waiting     = (state_q == S_FETCH) || (state_q == S_IWAIT) ||
                         (state_q == S_MEM)   || (state_q == S_DWAIT);

    // Handshakes: a request is accepted on a cycle with valid & ready; valid and its
    // address/wen hold until then and drop the cycle after. Responses are only
    // honoured in IWAIT/DWAIT, i.e. no earlier than the cycle after acceptance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        op_d      = op_q;
        rd_d      = rd_q;
        fault_d   = fault_q;

        case (state_q)
            S_FETCH: begin
                if (imem_req_ready) begin
                    state_d = S_IWAIT;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_IWAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                op_d = op_type;
                rd_d = rd;
                case (op_type)
                    OP_EBREAK:                    state_d = S_HALT;
                    OP_LOAD, OP_STORE:            state_d = S_MEM;
                    OP_JUMP, OP_ELSE, OP_BRANCH:  state_d = S_WB;
                    default: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req_ready) begin
                    state_d = (op_q == OP_STORE) ? S_WB : S_DWAIT;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_DWAIT: begin
                if (dmem_rvalid) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_WB: begin
                if (op_q == OP_JUMP) begin
                    pc_d = alu_result & ~32'd1;
                end else if ((op_q == OP_BRANCH) && branch_taken) begin
                    pc_d = pc_q + branch_target;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
        endcase

        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (waiting) begin
            wait_d = wait_inc[7:0];
        end

        // Write-back controls are decided on the edge into WB so they are plain flops.
        rf_we_d  = 1'b0;
        wb_sel_d = 2'd0;
        if (state_d == S_WB) begin
            rf_we_d  = ((op_d == OP_JUMP) || (op_d == OP_ELSE) || (op_d == OP_LOAD)) &&
                       (rd_d != 5'd0);
            wb_sel_d = (op_d == OP_JUMP) ? 2'd1 : ((op_d == OP_LOAD) ? 2'd2 : 2'd0);
        end
        dmem_wen_d = (state_d == S_MEM) && (op_d == OP_STORE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= 32'd0;
            instret_q  <= 32'd0;
            op_q       <= 5'd0;
            rd_q       <= 5'd0;
            wait_q     <= 8'd0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 2'd0;
            dmem_wen_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            instret_q  <= instret_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            wait_q     <= wait_d;
            rf_we_q    <= rf_we_d;
            wb_sel_q   <= wb_sel_d;
            dmem_wen_q <= dmem_wen_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_req_valid = (state_q == S_FETCH);
    assign dmem_req_valid = (state_q == S_MEM);
    assign halt           = (state_q == S_HALT);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign instret        = instret_q;
    assign rf_we          = rf_we_q;
    assign wb_sel         = wb_sel_q;
    assign dmem_wen       = dmem_wen_q;
    assign fault          = fault_q;
    assign state          = state_q;

endmodule

// File: tb/tb_ysyx_25050147_mc_ctrl.sv
// Bench for ysyx_25050147_mc_ctrl: directed vector table, hand-written reset/wrap
// sequences and randomized instructions checked against a cycle-budget model.
module tb_ysyx_25050147_mc_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 4;
    localparam logic [4:0]  OP_EBREAK = 5'd0;
    localparam logic [4:0]  OP_JUMP   = 5'd1;
    localparam logic [4:0]  OP_ELSE   = 5'd2;
    localparam logic [4:0]  OP_STORE  = 5'd4;
    localparam logic [4:0]  OP_LOAD   = 5'd8;
    localparam logic [4:0]  OP_BRANCH = 5'd16;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_wen, dmem_rvalid;
    logic [4:0]  op_type, rd;
    logic [31:0] branch_target, alu_result;
    logic        branch_taken;
    logic [31:0] pc, inst, instret;
    logic        rf_we, halt, fault;
    logic [1:0]  wb_sel;
    logic [2:0]  state;

    ysyx_25050147_mc_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_wen(dmem_wen), .dmem_rvalid(dmem_rvalid),
        .op_type(op_type), .rd(rd), .branch_target(branch_target),
        .alu_result(alu_result), .branch_taken(branch_taken),
        .pc(pc), .inst(inst), .rf_we(rf_we), .wb_sel(wb_sel), .halt(halt),
        .fault(fault), .instret(instret), .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model state and expectations
    logic [31:0] m_pc, m_instret, m_inst;
    logic [31:0] exp_q[$];
    int   e_end, e_we, e_mem, e_wen;
    logic [1:0] e_wbsel;
    logic e_halt, e_fault;

    // observations collected by run_instr
    int   r_end, r_we_cnt, r_we_cyc, r_mem_cyc, r_wen_cyc, r_excl_bad, r_req_after_halt;
    logic [1:0] r_wb_sel;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rvalid    = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rvalid    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_state", 32'(state), 32'd0);
        check("rst_imem_valid", 32'(imem_req_valid), 32'd1);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_wb_sel", 32'(wb_sel), 32'd0);
        check("rst_dmem", 32'({dmem_req_valid, dmem_wen}), 32'd0);
        rst_n     = 1'b1;
        m_pc      = RST_PC;
        m_instret = 32'd0;
        m_inst    = 32'd0;
    endtask

    // Driver: one instruction from its first FETCH cycle; df/di/dm/dd are the number
    // of cycles the awaited ready/rvalid is held low before it is given.
    task automatic run_instr(input logic [4:0] op, input logic [4:0] rdv, input logic [31:0] bt,
                             input logic [31:0] alu, input logic tk, input int df, input int di,
                             input int dm, input int dd, input logic [31:0] word);
        int ph, cnt, cyc;
        bit done;
        op_type = op; rd = rdv; branch_target = bt; alu_result = alu; branch_taken = tk;
        imem_rdata = word;
        r_end = -1; r_we_cnt = 0; r_we_cyc = -1; r_mem_cyc = 0; r_wen_cyc = 0;
        r_excl_bad = 0; r_req_after_halt = 0; r_wb_sel = 2'd3;
        ph = 0; cnt = 0; cyc = 1; done = 0;
        while (!done && cyc <= 80) begin
            clear_inputs();
            if (rf_we) begin
                r_we_cnt++;
                r_wb_sel = wb_sel;
                r_we_cyc = cyc;
            end
            if (dmem_req_valid) begin
                r_mem_cyc++;
                if (dmem_wen) r_wen_cyc++;
            end
            if (int'(rf_we) + int'(imem_req_valid) + int'(dmem_req_valid) > 1) r_excl_bad++;
            if (halt) begin
                r_end = cyc;
                for (int j = 0; j < 3; j++) begin
                    step();
                    if (imem_req_valid || dmem_req_valid || rf_we) r_req_after_halt++;
                end
                done = 1;
            end else if (imem_req_valid && ph >= 2) begin
                r_end = cyc;
                done  = 1;
            end else begin
                case (ph)
                    0: if (imem_req_valid) begin
                        if (cnt >= df) begin imem_req_ready = 1'b1; ph = 1; cnt = 0; end
                        else cnt++;
                    end
                    1: begin
                        if (cnt >= di) begin imem_rvalid = 1'b1; ph = 2; cnt = 0; end
                        else cnt++;
                    end
                    2: if (dmem_req_valid) begin
                        if (cnt >= dm) begin
                            dmem_req_ready = 1'b1;
                            ph  = (op == OP_LOAD) ? 3 : 4;
                            cnt = 0;
                        end else cnt++;
                    end
                    3: begin
                        if (cnt >= dd) begin dmem_rvalid = 1'b1; ph = 4; end
                        else cnt++;
                    end
                    default: ;
                endcase
                step();
                cyc++;
            end
        end
    endtask

    // Model: walks the phase budget with plain arithmetic (cycle 1 = first FETCH cycle).
    task automatic model_instr(input logic [4:0] op, input logic [4:0] rdv, input logic [31:0] bt,
                               input logic [31:0] alu, input logic tk, input int df, input int di,
                               input int dm, input int dd, input logic [31:0] word);
        int t;
        bit stop, legal, is_mem;
        legal  = op inside {OP_EBREAK, OP_JUMP, OP_ELSE, OP_STORE, OP_LOAD, OP_BRANCH};
        is_mem = (op == OP_STORE) || (op == OP_LOAD);
        e_we = 0; e_wbsel = 2'd0; e_mem = 0; e_wen = 0; e_fault = 1'b0; stop = 0; t = 1;
        if (df >= TO) begin stop = 1; e_fault = 1'b1; e_end = t + TO; end
        else t += df + 1;
        if (!stop) begin
            if (di >= TO) begin stop = 1; e_fault = 1'b1; e_end = t + TO; end
            else begin t += di + 1; m_inst = word; end
        end
        if (!stop) begin
            t += 1;
            if (op == OP_EBREAK) begin stop = 1; e_end = t + 1; end
            else if (!legal) begin stop = 1; e_fault = 1'b1; e_end = t + 1; end
            else t += 1;
        end
        if (!stop && is_mem) begin
            if (dm >= TO) begin stop = 1; e_fault = 1'b1; e_end = t + TO; e_mem = TO; end
            else begin e_mem = dm + 1; t += dm + 1; end
            if (op == OP_STORE) e_wen = e_mem;
        end
        if (!stop && op == OP_LOAD) begin
            if (dd >= TO) begin stop = 1; e_fault = 1'b1; e_end = t + TO; end
            else t += dd + 1;
        end
        if (!stop) begin
            e_we    = ((op == OP_JUMP || op == OP_ELSE || op == OP_LOAD) && rdv != 5'd0) ? 1 : 0;
            e_wbsel = (op == OP_JUMP) ? 2'd1 : ((op == OP_LOAD) ? 2'd2 : 2'd0);
            if (op == OP_JUMP) m_pc = {alu[31:1], 1'b0};
            else if (op == OP_BRANCH && tk) m_pc = m_pc + bt;
            else m_pc = m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
            e_end = t + 1;
        end
        e_halt = stop;
        exp_q.push_back(m_pc);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rdv;
        logic [31:0] bt;
        logic [31:0] alu;
        logic        tk;
        int          df, di, dm, dd;
        logic [31:0] x_pc;
        logic [31:0] x_ir;
        int          x_we;
        logic [1:0]  x_wbsel;
        int          x_wen;
        logic        x_halt;
        logic        x_fault;
        int          x_end;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [4:0] op, input logic [4:0] rdv, input logic [31:0] bt,
                           input logic [31:0] alu, input logic tk, input int df, input int di,
                           input int dm, input int dd, input logic [31:0] x_pc,
                           input logic [31:0] x_ir, input int x_we, input logic [1:0] x_wbsel,
                           input int x_wen, input logic x_halt, input logic x_fault,
                           input int x_end);
        vec_t v;
        v.op = op; v.rdv = rdv; v.bt = bt; v.alu = alu; v.tk = tk;
        v.df = df; v.di = di; v.dm = dm; v.dd = dd;
        v.x_pc = x_pc; v.x_ir = x_ir; v.x_we = x_we; v.x_wbsel = x_wbsel; v.x_wen = x_wen;
        v.x_halt = x_halt; v.x_fault = x_fault; v.x_end = x_end;
        vq.push_back(v);
    endtask

    function automatic int rnd_delay();
        if ($urandom_range(0, 24) == 0) return int'($urandom_range(4, 6));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        int we_seen;
        rst_n = 1'b0;
        clear_inputs();
        op_type = 5'd0; rd = 5'd0; branch_target = 32'd0; alu_result = 32'd0;
        branch_taken = 1'b0; imem_rdata = 32'd0;

        //      op         rd  bt            alu           tk df di dm dd  pc            ir we sel wen h f end
        add_vec(OP_ELSE,   1,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h8000_0004, 1, 1, 0, 0, 0, 0, 6);
        add_vec(OP_ELSE,   0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h8000_0004, 1, 0, 0, 0, 0, 0, 6);
        add_vec(OP_BRANCH, 3,  32'h10,       32'h0,        1, 0, 0, 0, 0, 32'h8000_0010, 1, 0, 0, 0, 0, 0, 6);
        add_vec(OP_BRANCH, 3,  32'h10,       32'h0,        0, 0, 0, 0, 0, 32'h8000_0004, 1, 0, 0, 0, 0, 0, 6);
        add_vec(OP_JUMP,   1,  32'h0,        32'h8000_0103, 0, 0, 0, 0, 0, 32'h8000_0102, 1, 1, 1, 0, 0, 0, 6);
        add_vec(OP_LOAD,   5,  32'h0,        32'h0,        0, 0, 0, 3, 1, 32'h8000_0004, 1, 1, 2, 0, 0, 0, 12);
        add_vec(OP_STORE,  7,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h8000_0004, 1, 0, 0, 1, 0, 0, 7);
        add_vec(OP_EBREAK, 0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 5);
        add_vec(5'd3,      1,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 1, 5);
        add_vec(OP_ELSE,   1,  32'h0,        32'h0,        0, 0, 9, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 1, 6);
        add_vec(OP_STORE,  0,  32'h0,        32'h0,        0, 0, 0, 5, 0, 32'h8000_0000, 0, 0, 0, 4, 1, 1, 9);
        add_vec(OP_JUMP,   0,  32'h0,        32'hFFFF_FFFD, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 6);
        add_vec(OP_BRANCH, 0,  32'hFFFF_FFF0, 32'h0,       1, 0, 0, 0, 0, 32'h7FFF_FFF0, 1, 0, 0, 0, 0, 0, 6);
        add_vec(OP_ELSE,   2,  32'h0,        32'h0,        0, 4, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 1, 5);
        add_vec(OP_LOAD,   2,  32'h0,        32'h0,        0, 0, 0, 0, 4, 32'h8000_0000, 0, 0, 0, 0, 1, 1, 10);
        add_vec(OP_LOAD,   9,  32'h0,        32'h0,        0, 2, 1, 0, 0, 32'h8000_0004, 1, 1, 2, 0, 0, 0, 11);

        for (int i = 0; i < vq.size(); i++) begin
            do_reset();
            run_instr(vq[i].op, vq[i].rdv, vq[i].bt, vq[i].alu, vq[i].tk,
                      vq[i].df, vq[i].di, vq[i].dm, vq[i].dd, 32'h0010_0093 + 32'(i));
            check($sformatf("v%0d_pc", i), pc, vq[i].x_pc);
            check($sformatf("v%0d_instret", i), instret, vq[i].x_ir);
            check($sformatf("v%0d_rf_we_cnt", i), 32'(r_we_cnt), 32'(vq[i].x_we));
            check($sformatf("v%0d_wen_cycles", i), 32'(r_wen_cyc), 32'(vq[i].x_wen));
            check($sformatf("v%0d_halt", i), 32'(halt), 32'(vq[i].x_halt));
            check($sformatf("v%0d_fault", i), 32'(fault), 32'(vq[i].x_fault));
            check($sformatf("v%0d_end_cycle", i), 32'(r_end), 32'(vq[i].x_end));
            check($sformatf("v%0d_exclusive", i), 32'(r_excl_bad), 32'd0);
            check($sformatf("v%0d_req_after_halt", i), 32'(r_req_after_halt), 32'd0);
            if (vq[i].x_we > 0) begin
                check($sformatf("v%0d_wb_sel", i), 32'(r_wb_sel), 32'(vq[i].x_wbsel));
                check($sformatf("v%0d_we_cycle", i), 32'(r_we_cyc), 32'(vq[i].x_end - 1));
            end
        end

        // PC wrap: jump to 0xFFFF_FFFC then a plain ALU op.
        do_reset();
        run_instr(OP_JUMP, 5'd0, 32'd0, 32'hFFFF_FFFD, 1'b0, 0, 0, 0, 0, 32'h0000_006F);
        run_instr(OP_ELSE, 5'd2, 32'd0, 32'd0, 1'b0, 0, 0, 0, 0, 32'h0000_0113);
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_instret", instret, 32'd2);
        check("wrap_rf_we_cnt", 32'(r_we_cnt), 32'd1);

        // Stray fetch response while still in FETCH is ignored.
        do_reset();
        imem_rdata  = 32'hDEAD_BEEF;
        imem_rvalid = 1'b1;
        step();
        step();
        imem_rvalid = 1'b0;
        check("stray_state", 32'(state), 32'd0);
        check("stray_inst", inst, 32'd0);
        check("stray_imem_valid", 32'(imem_req_valid), 32'd1);
        run_instr(OP_ELSE, 5'd3, 32'd0, 32'd0, 1'b0, 0, 0, 0, 0, 32'h1234_5678);
        check("stray_inst_after", inst, 32'h1234_5678);

        // Reset asserted mid-DWAIT aborts without write-back.
        do_reset();
        op_type = OP_LOAD; rd = 5'd4; imem_rdata = 32'h0040_2203;
        imem_req_ready = 1'b1; step();
        imem_req_ready = 1'b0; imem_rvalid = 1'b1; step();
        imem_rvalid = 1'b0; step();
        step();
        dmem_req_ready = 1'b1; step();
        dmem_req_ready = 1'b0;
        check("mid_state_dwait", 32'(state), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_pc", pc, RST_PC);
        check("mid_state", 32'(state), 32'd0);
        check("mid_imem_valid", 32'(imem_req_valid), 32'd1);
        check("mid_instret", instret, 32'd0);
        check("mid_rf_we", 32'(rf_we), 32'd0);
        check("mid_dmem_valid", 32'(dmem_req_valid), 32'd0);
        dmem_rvalid = 1'b1;
        step();
        rst_n = 1'b1;
        we_seen = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            dmem_rvalid = 1'b0;
            if (rf_we) we_seen++;
        end
        check("mid_no_rf_we", 32'(we_seen), 32'd0);
        check("mid_instret_after", instret, 32'd0);
        check("mid_state_after", 32'(state), 32'd0);

        // Randomized instruction stream against the model.
        do_reset();
        for (int k = 0; k < 80; k++) begin
            int r, df, di, dm, dd;
            logic [4:0]  op, rdv;
            logic [31:0] bt, alu, word;
            logic        tk;
            r = int'($urandom_range(0, 39));
            if (r == 0) op = OP_EBREAK;
            else if (r == 1) begin
                do op = 5'($urandom_range(0, 31));
                while (op inside {OP_EBREAK, OP_JUMP, OP_ELSE, OP_STORE, OP_LOAD, OP_BRANCH});
            end
            else if (r < 9)  op = OP_JUMP;
            else if (r < 18) op = OP_ELSE;
            else if (r < 24) op = OP_STORE;
            else if (r < 31) op = OP_LOAD;
            else             op = OP_BRANCH;
            rdv  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bt   = $urandom() & ~32'd1;
            alu  = $urandom();
            tk   = 1'($urandom_range(0, 1));
            word = $urandom();
            df = rnd_delay(); di = rnd_delay(); dm = rnd_delay(); dd = rnd_delay();
            model_instr(op, rdv, bt, alu, tk, df, di, dm, dd, word);
            run_instr(op, rdv, bt, alu, tk, df, di, dm, dd, word);
            check($sformatf("r%0d_pc", k), pc, exp_q.pop_front());
            check($sformatf("r%0d_instret", k), instret, m_instret);
            check($sformatf("r%0d_inst", k), inst, m_inst);
            check($sformatf("r%0d_rf_we_cnt", k), 32'(r_we_cnt), 32'(e_we));
            check($sformatf("r%0d_end_cycle", k), 32'(r_end), 32'(e_end));
            check($sformatf("r%0d_halt", k), 32'(halt), 32'(e_halt));
            check($sformatf("r%0d_fault", k), 32'(fault), 32'(e_fault));
            check($sformatf("r%0d_mem_cycles", k), 32'(r_mem_cyc), 32'(e_mem));
            check($sformatf("r%0d_wen_cycles", k), 32'(r_wen_cyc), 32'(e_wen));
            check($sformatf("r%0d_exclusive", k), 32'(r_excl_bad), 32'd0);
            check($sformatf("r%0d_req_after_halt", k), 32'(r_req_after_halt), 32'd0);
            if (e_we > 0) check($sformatf("r%0d_wb_sel", k), 32'(r_wb_sel), 32'(e_wbsel));
            if (e_halt) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
